// File: rtl/seg7_marquee.sv
// seg7_marquee: host-loadable, double-buffered scrolling text driver for a
// bank of active-low 7-segment digits. Characters are written into a back
// bank; a commit swaps banks and restarts the display in the selected mode.
module seg7_marquee #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_DEPTH  = 32,
    parameter int TICK_DIV   = 12_000_000,
    parameter int AW         = $clog2(MSG_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [7:0]              wr_data,
    input  logic [AW:0]             msg_len,
    input  logic                    commit,
    input  logic [1:0]              mode,
    output logic [7*NUM_DIGITS-1:0] seg_n,
    output logic [AW:0]             ptr,
    output logic                    wrap_pulse
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_SCROLL = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_FWD  = 1'b0,
        DIR_BACK = 1'b1
    } dir_t;

    localparam int               DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [AW:0]      DEPTH_L   = (AW+1)'(MSG_DEPTH);
    localparam logic [AW:0]      DIGITS_L  = (AW+1)'(NUM_DIGITS);
    localparam logic [AW:0]      PTR_TWO   = (AW+1)'(2);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;

    // Clamp a requested message length to the bank capacity.
    function automatic logic [AW:0] sat_len(input logic [AW:0] n);
        return (n > DEPTH_L) ? DEPTH_L : n;
    endfunction

    // ASCII to active-low {g,f,e,d,c,b,a}; lowercase folds onto uppercase,
    // anything without a glyph (including W and Z) is blank.
    function automatic logic [6:0] font(input logic [7:0] ch);
        logic [7:0] c;
        logic [6:0] g;
        c = ((ch >= 8'h61) && (ch <= 8'h7A)) ? (ch - 8'h20) : ch;
        case (c)
            8'h30: g = 7'b1000000; // 0
            8'h31: g = 7'b1111001; // 1
            8'h32: g = 7'b0100100; // 2
            8'h33: g = 7'b0110000; // 3
            8'h34: g = 7'b0011001; // 4
            8'h35: g = 7'b0010010; // 5
            8'h36: g = 7'b0000010; // 6
            8'h37: g = 7'b1111000; // 7
            8'h38: g = 7'b0000000; // 8
            8'h39: g = 7'b0010000; // 9
            8'h41: g = 7'b0001000; // A
            8'h42: g = 7'b0000011; // B
            8'h43: g = 7'b1000110; // C
            8'h44: g = 7'b0100001; // D
            8'h45: g = 7'b0000110; // E
            8'h46: g = 7'b0001110; // F
            8'h47: g = 7'b1000010; // G
            8'h48: g = 7'b0001001; // H
            8'h49: g = 7'b1001111; // I
            8'h4A: g = 7'b1100001; // J
            8'h4B: g = 7'b0001010; // K
            8'h4C: g = 7'b1000111; // L
            8'h4D: g = 7'b1001000; // M
            8'h4E: g = 7'b0101011; // N
            8'h4F: g = 7'b1000000; // O
            8'h50: g = 7'b0001100; // P
            8'h51: g = 7'b0011000; // Q
            8'h52: g = 7'b0101111; // R
            8'h53: g = 7'b0010010; // S
            8'h54: g = 7'b0000111; // T
            8'h55: g = 7'b1000001; // U
            8'h56: g = 7'b1100011; // V
            8'h58: g = 7'b0001001; // X
            8'h59: g = 7'b0010001; // Y
            8'h2D: g = 7'b0111111; // -
            8'h5F: g = 7'b1110111; // _
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Message storage: two banks, the active one is displayed, the other is
    // the host's write target. Contents are deliberately not reset.
    logic [7:0] mem [2][MSG_DEPTH];

    // Control state.
    logic             active_bank;
    logic [AW:0]      len;
    dir_t             dir;
    logic             blink_on;
    logic [DIV_W-1:0] div_cnt;
    mode_t            last_mode;

    // Next-state values.
    logic             active_nxt;
    logic [AW:0]      len_nxt;
    logic [AW:0]      ptr_nxt;
    dir_t             dir_nxt;
    logic             blink_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic             wrap_nxt;

    mode_t            mode_cur;
    logic             restart;
    logic             tick;
    logic [AW:0]      ptr_inc;
    logic [AW:0]      bounce_max;

    assign mode_cur   = mode_t'(mode);
    assign restart    = commit || (mode_cur != last_mode);
    assign tick       = (div_cnt == DIV_LAST);
    assign ptr_inc    = ptr + 1'b1;
    assign bounce_max = len - DIGITS_L;

    // Next-state: restart (commit or mode change) beats tick; tick advances
    // the window or blink phase according to the current mode.
    always_comb begin
        active_nxt = active_bank;
        len_nxt    = len;
        ptr_nxt    = ptr;
        dir_nxt    = dir;
        blink_nxt  = blink_on;
        div_nxt    = tick ? '0 : (div_cnt + 1'b1);
        wrap_nxt   = 1'b0;

        if (restart) begin
            if (commit) begin
                active_nxt = ~active_bank;
                len_nxt    = sat_len(msg_len);
            end
            ptr_nxt   = '0;
            dir_nxt   = DIR_FWD;
            blink_nxt = 1'b1;
            div_nxt   = '0;
        end else if (tick) begin
            case (mode_cur)
                MODE_SCROLL: begin
                    if (ptr >= len) begin
                        ptr_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        ptr_nxt = ptr_inc;
                    end
                end
                MODE_BOUNCE: begin
                    if (len <= DIGITS_L) begin
                        ptr_nxt = '0;
                        dir_nxt = DIR_FWD;
                    end else if (dir == DIR_FWD) begin
                        // Flip direction on arrival at the far end.
                        if (ptr_inc >= bounce_max) begin
                            ptr_nxt = bounce_max;
                            dir_nxt = DIR_BACK;
                        end else begin
                            ptr_nxt = ptr_inc;
                        end
                    end else begin
                        // Arrival back at 0 completes one pass.
                        if (ptr < PTR_TWO) begin
                            ptr_nxt  = '0;
                            dir_nxt  = DIR_FWD;
                            wrap_nxt = 1'b1;
                        end else begin
                            ptr_nxt = ptr - 1'b1;
                        end
                    end
                end
                MODE_BLINK: begin
                    ptr_nxt   = '0;
                    blink_nxt = ~blink_on;
                end
                default: begin
                    ptr_nxt = '0;
                end
            endcase
        end
    end

    // Control register stage: all display state updates on the sampling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_bank <= 1'b0;
            len         <= '0;
            ptr         <= '0;
            dir         <= DIR_FWD;
            blink_on    <= 1'b1;
            div_cnt     <= '0;
            last_mode   <= MODE_STATIC;
            wrap_pulse  <= 1'b0;
        end else begin
            active_bank <= active_nxt;
            len         <= len_nxt;
            ptr         <= ptr_nxt;
            dir         <= dir_nxt;
            blink_on    <= blink_nxt;
            div_cnt     <= div_nxt;
            last_mode   <= mode_cur;
            wrap_pulse  <= wrap_nxt;
        end
    end

    // Host writes always land in the bank that is not being displayed; a
    // write alongside commit therefore joins the message being committed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[~active_bank][wr_addr] <= wr_data;
        end
    end

    // Window decode: digit k shows char[ptr+k] when inside the message.
    logic [7*NUM_DIGITS-1:0] seg_win;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [AW+1:0] idx;
        logic [7:0]    ch;
        assign idx = {1'b0, ptr} + (AW+2)'(k);
        assign ch  = mem[active_bank][idx[AW-1:0]];
        assign seg_win[7*(NUM_DIGITS-1-k) +: 7] = (idx < {1'b0, len}) ? font(ch) : SEG_BLANK;
    end

    logic blank_all;
    assign blank_all = (last_mode == MODE_BLINK) && !blink_on;

    // Output register stage: segments follow the control state one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_n <= '1;
        end else begin
            seg_n <= blank_all ? '1 : seg_win;
        end
    end

endmodule

// File: doc/seg7_marquee.md
# seg7_marquee

Parametrised scrolling-text driver for a bank of active-low 7-segment digits. It replaces the fixed-text information display with a host-loadable, double-buffered message store, runtime-selectable display modes and a configurable scroll rate. It sits between the control FSM, which writes ASCII status text, and the board HEX outputs.

## Interface
- NUM_DIGITS, 6, number of physical digits (2..8)
- MSG_DEPTH, 32, characters per message buffer (power of two, 8..64)
- TICK_DIV, 12_000_000, clk cycles per scroll/blink tick (≥2)
- AW, $clog2(MSG_DEPTH), address width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- wr_en  in  1  write one character to the back buffer
- wr_addr  in  AW  back-buffer character index
- wr_data  in  8  ASCII character
- msg_len  in  AW+1  message length, sampled on commit
- commit  in  1  single-cycle pulse: swap buffers and restart display
- mode  in  2  00 static, 01 scroll, 10 bounce, 11 blink
- seg_n  out  7*NUM_DIGITS  segments {g,f,e,d,c,b,a} per digit, active low; digit 0 (leftmost) in the MSB slice
- ptr  out  AW+1  current window start index
- wrap_pulse  out  1  one-cycle pulse at the end of each scroll/bounce pass

## Operation
- Two MSG_DEPTH×8 banks. `wr_en` writes `wr_data` into the back bank at `wr_addr`. Bank contents are not reset.
- Commit: toggle the active bank, latch len = min(msg_len, MSG_DEPTH), ptr←0, dir←forward, divider←0, blink phase←on. A write in the same cycle as commit lands in the pre-commit back bank, so it is part of the committed message.
- Priority per edge: commit > mode change (mode ≠ registered last mode) > tick. A mode change restarts ptr, dir, divider and blink phase exactly as commit does, but without a bank swap.
- Divider counts 0..TICK_DIV-1. A tick is asserted in the cycle where count = TICK_DIV-1, and count then returns to 0.
- Window: digit k shows char[ptr+k] if ptr+k < len; otherwise it shows blank. The sum is computed at AW+2 bits with no wrap.
- Static (00): ptr is held at 0. Ticks are ignored.
- Scroll (01): on each tick, ptr increments. On the tick where ptr = len, ptr←0 and wrap_pulse fires. With len = 0, ptr stays 0 and wrap_pulse fires on every tick.
- Bounce (10): if len ≤ NUM_DIGITS, ptr stays 0 and there is no pulse. Otherwise ptr steps ±1 per tick between 0 and len−NUM_DIGITS, reversing at each end. wrap_pulse fires on the tick that returns ptr to 0.
- Blink (11): ptr is held at 0. Each tick toggles the blink phase, and in the off phase all digits are blank.
- Font: 0–9 use standard codes ('0'=1000000, '1'=1111001, '8'=0000000). Letters A–Y use the team letter font ('A'=0001000, 'E'=0000110, 'O'=1000000, 'S'=0010010). Lowercase a–z maps to uppercase. '-'=0111111, '_'=1110111, space=1111111. W, Z and all other codes display blank.

## Timing
- Reset values:
  - seg_n all ones; ptr 0; wrap_pulse 0.
  - len 0, active bank 0, dir forward, divider 0, blink on.
  - Last mode takes the value 00, so a non-00 mode present at reset release triggers a restart on the first edge.
- State (bank, len, ptr, dir, blink) updates on the sampling edge. seg_n is registered from that state and changes one edge later.
- Commit at edge N: ptr = 0 after edge N, and seg_n shows the new text after edge N+1.
- wrap_pulse is registered and asserted in the cycle after the tick that causes the wrap, for one cycle only.
- A write to the back bank never affects seg_n before commit.
- Reset mid-scroll returns to the reset values immediately (asynchronous); the divider restarts from 0.

## Test plan
- Reset, then commit with len=0 in mode 00 -> seg_n = all ones; ptr = 0; no wrap_pulse.
- TICK_DIV=4, NUM_DIGITS=6: write "HELLO" (len 5), commit, mode 01 -> ptr steps 0,1,..,5 every 4 cycles; digit 0 reads 'H','E','L','L','O',blank; wrap_pulse fires once as ptr returns to 0.
- Mode 10 with the 10-character message "0123456789" -> ptr sequence 0,1,2,3,4,3,2,1,0; wrap_pulse on the return to 0; with len=6, ptr stays 0 permanently.
- Mode 11, "ABC" -> seg_n alternates between "ABC" plus blanks and all ones every 4 cycles; starts in the on phase after commit.
- Write "xyz" to the back bank without commit -> seg_n unchanged. Commit with a simultaneous wr_en at addr 3 -> digits show 'X','Y',blank ('Z' has no glyph),then the addr-3 char two edges later.
- Mid-scroll events: assert reset -> seg_n all ones the same cycle. Change mode 01→00 -> ptr 0 next edge, divider restarted. Commit and mode change in the same cycle -> single restart with a bank swap.
